// File: rtl/irq_trap_ctrl.sv
// Machine-mode interrupt/MRET trap sequencer between csr_unit and fetch.
// Define TRAP_VECTORED_EN to honour MTVEC vectored mode (base + cause*4).
module irq_trap_ctrl #(
  parameter logic [31:0] IRQ_MASK = 32'hFFFF_0888
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [31:0] ip_i,
  input  logic [31:0] ie_i,
  input  logic [31:0] status_i,
  input  logic [31:0] vec_i,
  input  logic [31:0] mepc_i,
  input  logic        mret_i,
  output logic        flush_req_o,
  input  logic        flush_ack_i,
  input  logic [31:0] flush_pc_i,
  output logic        interrupt_valid_o,
  output logic [31:0] ecause_o,
  output logic [31:0] epc_o,
  output logic        ret_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i,
  output logic        stop_counters_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_TRAP,
    S_RET,
    S_REDIR
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  idx_q;
  logic [31:0] target_q;
  logic [31:0] pend;
  logic [5:0]  pick;
  logic        pend_any;
  logic [4:0]  pend_idx;
  logic [31:0] base;
  logic [31:0] target_d;
  logic        unused_ok;

  // Returns {found, index}: MEI, MSI, MTI, then platform bits 16..31 lowest first.
  function automatic logic [5:0] pick_irq(input logic [31:0] p);
    logic [5:0] r;
    r = 6'd0;
    if (p[11]) begin
      r = {1'b1, 5'd11};
    end else if (p[3]) begin
      r = {1'b1, 5'd3};
    end else if (p[7]) begin
      r = {1'b1, 5'd7};
    end else begin
      for (int i = 31; i >= 16; i--) begin
        if (p[i]) r = {1'b1, 5'(i)};
      end
    end
    return r;
  endfunction

  assign pend     = status_i[3] ? (ip_i & ie_i & IRQ_MASK) : 32'h0;
  assign pick     = pick_irq(pend);
  assign pend_any = pick[5];
  assign pend_idx = pick[4:0];
  assign base     = {vec_i[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  assign target_d  = (vec_i[1:0] == 2'b01) ? (base + {25'b0, pend_idx, 2'b00}) : base;
  assign unused_ok = ^{status_i[31:4], status_i[2:0]};
`else
  assign target_d  = base;
  assign unused_ok = ^{status_i[31:4], status_i[2:0], vec_i[1:0]};
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= S_IDLE;
      idx_q         <= 5'd0;
      target_q      <= 32'h0;
      ecause_o      <= 32'h0;
      epc_o         <= 32'h0;
      redirect_pc_o <= 32'h0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (pend_any) begin
            idx_q    <= pend_idx;
            target_q <= target_d;
          end
        end
        S_DRAIN: begin
          // Cause/EPC only change on entry to TRAP so csr_unit sees stable values elsewhere.
          if (flush_ack_i) begin
            ecause_o <= {1'b1, 26'b0, idx_q};
            epc_o    <= flush_pc_i;
          end
        end
        S_TRAP:  redirect_pc_o <= target_q;
        S_RET:   redirect_pc_o <= mepc_i;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d           = state_q;
    flush_req_o       = 1'b0;
    interrupt_valid_o = 1'b0;
    ret_o             = 1'b0;
    redirect_valid_o  = 1'b0;
    stop_counters_o   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // An interrupt pre-empts a coincident MRET; the MRET re-executes after return.
        if (pend_any) begin
          state_d = S_DRAIN;
        end else if (mret_i) begin
          state_d = S_RET;
        end
      end
      S_DRAIN: begin
        flush_req_o     = 1'b1;
        stop_counters_o = 1'b1;
        if (flush_ack_i) state_d = S_TRAP;
      end
      S_TRAP: begin
        interrupt_valid_o = 1'b1;
        stop_counters_o   = 1'b1;
        state_d           = S_REDIR;
      end
      S_RET: begin
        ret_o   = 1'b1;
        state_d = S_REDIR;
      end
      S_REDIR: begin
        redirect_valid_o = 1'b1;
        if (redirect_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Directed plus randomized bench for irq_trap_ctrl against a priority-list reference model.
module tb_irq_trap_ctrl;
  localparam logic [31:0] MASK = 32'hFFFF_0888;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic [31:0] ip_i, ie_i, status_i, vec_i, mepc_i, flush_pc_i;
  logic        mret_i, flush_ack_i, redirect_ready_i;
  logic        flush_req_o, interrupt_valid_o, ret_o, redirect_valid_o, stop_counters_o;
  logic [31:0] ecause_o, epc_o, redirect_pc_o;

  int tests = 0;
  int fails = 0;

  irq_trap_ctrl #(.IRQ_MASK(MASK)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .ip_i(ip_i), .ie_i(ie_i), .status_i(status_i),
    .vec_i(vec_i), .mepc_i(mepc_i), .mret_i(mret_i), .flush_req_o(flush_req_o),
    .flush_ack_i(flush_ack_i), .flush_pc_i(flush_pc_i), .interrupt_valid_o(interrupt_valid_o),
    .ecause_o(ecause_o), .epc_o(epc_o), .ret_o(ret_o), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o), .redirect_ready_i(redirect_ready_i),
    .stop_counters_o(stop_counters_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference model: architectural rules, not the RTL structure.
  function automatic logic [31:0] model_pend(input logic [31:0] ip, input logic [31:0] ie,
                                             input logic [31:0] st);
    return st[3] ? (ip & ie & MASK) : 32'h0;
  endfunction

  function automatic int model_idx(input logic [31:0] pend);
    int order[19];
    order[0] = 11;
    order[1] = 3;
    order[2] = 7;
    for (int k = 0; k < 16; k++) order[3+k] = 16 + k;
    foreach (order[k]) if (pend[order[k]]) return order[k];
    return -1;
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] vec, input int idx);
    logic [31:0] b;
    b = vec & ~32'h3;
`ifdef TRAP_VECTORED_EN
    if (vec[1:0] == 2'b01) return b + 32'(idx) * 32'd4;
`endif
    return b;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".flush_req"}, flush_req_o, 0);
    check({tag, ".int_valid"}, interrupt_valid_o, 0);
    check({tag, ".ret"}, ret_o, 0);
    check({tag, ".redir_valid"}, redirect_valid_o, 0);
    check({tag, ".stop_cnt"}, stop_counters_o, 0);
    check({tag, ".ecause"}, ecause_o, 0);
    check({tag, ".epc"}, epc_o, 0);
    check({tag, ".redir_pc"}, redirect_pc_o, 0);
  endtask

  // Holds the redirect for rdly refused cycles, then accepts it.
  task automatic redirect_accept(input string tag, input logic [31:0] pc, input int rdly);
    for (int k = 0; k < rdly; k++) begin
      check({tag, ".rv_hold"}, redirect_valid_o, 1);
      check({tag, ".pc_hold"}, redirect_pc_o, pc);
      mepc_i = $urandom;
      tick();
    end
    check({tag, ".rv_last"}, redirect_valid_o, 1);
    check({tag, ".pc_last"}, redirect_pc_o, pc);
    redirect_ready_i = 1'b1;
    mret_i = 1'b0;
    tick();
    redirect_ready_i = 1'b0;
    check({tag, ".rv_done"}, redirect_valid_o, 0);
    check({tag, ".ret_done"}, ret_o, 0);
  endtask

  // Called with the DUT just entered DRAIN.
  task automatic finish_trap(input string tag, input logic [31:0] pc, input int dly,
                             input logic [31:0] cause, input logic [31:0] target, input int rdly);
    check({tag, ".stop_drain"}, stop_counters_o, 1);
    for (int k = 0; k < dly; k++) begin
      tick();
      check({tag, ".drain_hold"}, flush_req_o, 1);
    end
    flush_ack_i = 1'b1;
    flush_pc_i  = pc;
    tick();
    flush_ack_i = 1'b0;
    flush_pc_i  = $urandom;
    ip_i   = 32'h0;
    mret_i = 1'b0;
    check({tag, ".int_valid"}, interrupt_valid_o, 1);
    check({tag, ".ecause"}, ecause_o, cause);
    check({tag, ".epc"}, epc_o, pc);
    check({tag, ".stop_trap"}, stop_counters_o, 1);
    check({tag, ".flush_off"}, flush_req_o, 0);
    tick();
    check({tag, ".int_pulse"}, interrupt_valid_o, 0);
    check({tag, ".stop_redir"}, stop_counters_o, 0);
    redirect_accept(tag, target, rdly);
    check({tag, ".ecause_keep"}, ecause_o, cause);
    check({tag, ".epc_keep"}, epc_o, pc);
  endtask

  task automatic txn(input string tag, input logic [31:0] ip, input logic [31:0] ie,
                     input logic [31:0] st, input logic [31:0] vec, input logic mret,
                     input logic [31:0] mepc, input logic [31:0] pc, input int dly, input int rdly);
    logic [31:0] pend;
    int idx;
    ip_i = ip; ie_i = ie; status_i = st; vec_i = vec; mret_i = mret; mepc_i = mepc;
    pend = model_pend(ip, ie, st);
    idx  = model_idx(pend);
    tick();
    if (idx >= 0) begin
      check({tag, ".flush_req"}, flush_req_o, 1);
      check({tag, ".no_ret"}, ret_o, 0);
      finish_trap(tag, pc, dly, 32'h8000_0000 | 32'(idx), model_target(vec, idx), rdly);
    end else if (mret) begin
      check({tag, ".ret"}, ret_o, 1);
      check({tag, ".no_flush"}, flush_req_o, 0);
      tick();
      check({tag, ".ret_pulse"}, ret_o, 0);
      redirect_accept(tag, mepc, rdly);
    end else begin
      check({tag, ".idle_flush"}, flush_req_o, 0);
      check({tag, ".idle_ret"}, ret_o, 0);
      check({tag, ".idle_rv"}, redirect_valid_o, 0);
    end
    ip_i = 32'h0;
    mret_i = 1'b0;
  endtask

  initial begin
    logic [31:0] rip, rie, rst, rvec;
    reset_ni = 1'b0;
    ip_i = 0; ie_i = 0; status_i = 0; vec_i = 0; mepc_i = 0; flush_pc_i = 0;
    mret_i = 0; flush_ack_i = 0; redirect_ready_i = 0;
    #1;
    check_all_zero("reset");
    tick();
    tick();
    reset_ni = 1'b1;
    tick();
    check_all_zero("post_reset");

    // Basic MEI trap with 3-cycle drain
    txn("t1", 32'h880, 32'h880, 32'h8, 32'h100, 1'b0, 32'h0, 32'h2040, 2, 1);
    // Vectored mode encodings (plain base when the feature is off)
    txn("t2a", 32'h880, 32'h880, 32'h8, 32'h101, 1'b0, 32'h0, 32'h2040, 2, 0);
    txn("t2b", 32'h0001_0000, 32'h0001_0000, 32'h8, 32'h101, 1'b0, 32'h0, 32'h44, 1, 0);

    // Global MIE gate
    ip_i = 32'h800; ie_i = 32'h800; status_i = 32'h0; vec_i = 32'h200;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t3.gated", flush_req_o, 0);
    end
    status_i = 32'h8;
    tick();
    check("t3.ungated", flush_req_o, 1);
    finish_trap("t3", 32'h77C, 0, 32'h8000_000B, 32'h200, 0);

    // MRET with two refused redirect cycles
    txn("t4", 32'h0, 32'h0, 32'h8, 32'h100, 1'b1, 32'h3000, 32'h0, 0, 2);

    // MRET collides with MSI; interrupt wins and survives ip dropping mid-drain
    ip_i = 32'h8; ie_i = 32'h8; status_i = 32'h8; vec_i = 32'h400; mret_i = 1'b1; mepc_i = 32'h3000;
    tick();
    check("t5.drain", flush_req_o, 1);
    check("t5.no_ret", ret_o, 0);
    ip_i = 32'h0;
    mret_i = 1'b0;
    tick();
    check("t5.still_drain", flush_req_o, 1);
    finish_trap("t5", 32'h1230, 1, 32'h8000_0003, 32'h400, 0);

    // Async reset mid-DRAIN, stale ack afterwards
    ip_i = 32'h800; ie_i = 32'h800; status_i = 32'h8;
    tick();
    check("t6.drain", flush_req_o, 1);
    #2 reset_ni = 1'b0;
    #1;
    check_all_zero("t6.rst_drain");
    ip_i = 32'h0;
    flush_ack_i = 1'b1;
    flush_pc_i = 32'hDEAD_BEEC;
    tick();
    reset_ni = 1'b1;
    tick();
    flush_ack_i = 1'b0;
    check("t6.stale_ack_iv", interrupt_valid_o, 0);
    check("t6.stale_ack_fr", flush_req_o, 0);
    check("t6.stale_ack_epc", epc_o, 0);

    // Async reset mid-REDIR
    mret_i = 1'b1; mepc_i = 32'h5554;
    tick();
    check("t6.ret", ret_o, 1);
    tick();
    check("t6.redir", redirect_valid_o, 1);
    mret_i = 1'b0;
    #2 reset_ni = 1'b0;
    #1;
    check_all_zero("t6.rst_redir");
    tick();
    reset_ni = 1'b1;
    tick();
    check("t6.idle_rv", redirect_valid_o, 0);
    check("t6.idle_ret", ret_o, 0);

    // Randomized transactions
    for (int n = 0; n < 60; n++) begin
      rip = $urandom;
      case ($urandom_range(0, 3))
        0:       rie = 32'h0;
        1:       rie = 32'h1 << $urandom_range(0, 31);
        2:       rie = $urandom;
        default: rie = $urandom & ~MASK;
      endcase
      rst  = $urandom;
      rvec = $urandom;
      if ($urandom_range(0, 1) == 1) rvec[1:0] = 2'b01;
      txn("rnd", rip, rie, rst, rvec, 1'($urandom_range(0, 1)), $urandom, $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/irq_trap_ctrl.md
Name: irq_trap_ctrl

Overview:
- Machine-mode trap sequencer that sits directly downstream of csr_unit and feeds it back.
- Consumes the CSR interrupt view: ip, ie, mtvec, mstatus, mepc.
- Prioritises pending interrupts, drains the pipeline through a flush handshake, then pulses interrupt_valid/ecause/epc into csr_unit.
- Issues the PC redirect to fetch; also sequences MRET (ret pulse plus redirect to mepc).

Parameters:
- IRQ_MASK, 32'hFFFF_0888, implemented interrupt bits; pending bits outside the mask are ignored.

Ports:
- clk_i  in  1  core clock
- reset_ni  in  1  asynchronous active-low reset
- ip_i  in  32  MIP from csr_unit
- ie_i  in  32  MIE from csr_unit
- status_i  in  32  MSTATUS from csr_unit; bit 3 is MIE
- vec_i  in  32  MTVEC from csr_unit
- mepc_i  in  32  MEPC from csr_unit
- mret_i  in  1  MRET decoded in execute, level, held until redirect accepted
- flush_req_o  out  1  request pipeline drain
- flush_ack_i  in  1  drain complete, 1-cycle pulse
- flush_pc_i  in  32  PC of oldest uncommitted instruction, valid with flush_ack_i
- interrupt_valid_o  out  1  1-cycle pulse to csr_unit
- ecause_o  out  32  cause for csr_unit
- epc_o  out  32  return PC for csr_unit
- ret_o  out  1  1-cycle pulse to csr_unit; sets MSTATUS.MIE
- redirect_valid_o  out  1  fetch redirect request
- redirect_pc_o  out  32  redirect target
- redirect_ready_i  in  1  fetch accepts redirect
- stop_counters_o  out  1  freeze mcycle/minstret while trap sequencing

Behaviour:
- Reset (reset_ni low, async):
  - state IDLE
  - all 1-bit outputs 0
  - ecause_o, epc_o, redirect_pc_o are 32'h0
  - latched cause/target registers are 0
- Pending vector: pend = ip_i & ie_i & IRQ_MASK, gated by status_i[3]. Evaluated only in IDLE.
- Priority, highest first:
  - bit 11 (MEI), then bit 3 (MSI), then bit 7 (MTI)
  - then bits 16..31, lowest index first
  - all other bits never selected
- Cause: {1'b1, 26'b0, idx[4:0]}, latched on leaving IDLE.
- Trap base: {vec_i[31:2], 2'b00}. Target computation is per the Optional Feature section.
- State machine:
  - IDLE:
    - pend != 0 → DRAIN; latch cause and target in the same cycle. The interrupt wins over a simultaneous mret_i; the MRET is flushed and re-executes after return.
    - else mret_i → RET.
  - DRAIN:
    - flush_req_o = 1 and stop_counters_o = 1.
    - Wait for flush_ack_i, then capture flush_pc_i and go → TRAP.
    - Latched cause is kept even if pend clears mid-drain; the trap is still taken.
  - TRAP:
    - Exactly one cycle.
    - interrupt_valid_o = 1, ecause_o = latched cause, epc_o = captured flush_pc_i, stop_counters_o = 1.
    - → REDIR with redirect_pc_o = latched target.
  - RET:
    - Exactly one cycle.
    - ret_o = 1, redirect_pc_o = mepc_i sampled this cycle.
    - → REDIR.
  - REDIR:
    - redirect_valid_o = 1; redirect_pc_o held stable.
    - Leave when redirect_valid_o & redirect_ready_i → IDLE.
    - pend is ignored here; MSTATUS.MIE update in csr_unit lands one cycle after the pulse.
- Latency:
  - Pend seen in IDLE → flush_req_o on the next cycle.
  - flush_ack_i → interrupt_valid_o on the next cycle → redirect_valid_o on the cycle after.
- ecause_o and epc_o hold their last values outside TRAP.
- flush_ack_i outside DRAIN is ignored.
- redirect_ready_i outside REDIR is ignored.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- Defined:
  - vec_i[1:0] == 2'b01 → target = base + (idx << 2)
  - any other mode → target = base
  - The addition wraps modulo 2^32.
- Undefined: target = base always; vec_i[1:0] is ignored.

Test Plan:
1. ie=32'h880, ip=32'h880, status=32'h8, vec=32'h100, flush_ack with flush_pc=32'h2040 after 3 cycles.
   - Expect ecause=32'h8000000B, epc=32'h2040, 1-cycle interrupt_valid.
   - Expect redirect_pc=32'h100.
2. Same stimulus with TRAP_VECTORED_EN defined, vec=32'h101.
   - Expect redirect_pc=32'h12C.
   - Repeat with ip=ie=32'h0001_0000: expect cause 32'h80000010 and target 32'h140.
3. status[3]=0 with ip=ie=32'h800 for 10 cycles.
   - Expect no flush_req_o.
   - Set status[3]=1: expect flush_req_o on the next cycle.
4. mret_i=1, mepc=32'h3000, no pending, redirect_ready low for 2 cycles.
   - Expect one ret_o pulse.
   - Expect redirect_valid_o held 3 cycles with pc 32'h3000, then IDLE.
5. mret_i and pend=32'h8 in the same IDLE cycle.
   - Expect the DRAIN path, cause 32'h80000003, and no ret_o.
   - Drop ip during DRAIN: the trap is still taken.
6. reset_ni low mid-DRAIN and mid-REDIR.
   - Expect all outputs 0 asynchronously.
   - Expect IDLE after release; a stale flush_ack_i is ignored.
